sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Responder end of the pipeline data-memory interface.
- Accepts one word-aligned read or write request from the MEM stage and runs a multi-cycle asynchronous SRAM cycle on the board's 32-bit external SRAM (two x16 parts).
- Holds the pipeline with a stall until the cycle completes, then returns raw load data; byte/half selection remains in the MEM stage.
- Instantiated beside the MEM stage; the top level builds the DQ tristate.

Parameters:
ADDR_W, 18, SRAM word-address width
RD_CYCLES, 2, cycles with OE_n low before read data is sampled (>=1)
WR_CYCLES, 2, cycles WE_n is held low (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  memory operation requested (MEM memop)
mem_wr  in  1  1 = write, 0 = read
mem_addr  in  32  byte address; bits [ADDR_W+1:2] used
mem_wdata  in  32  store data, already lane-aligned
mem_bwe  in  4  byte write enables, bit i = byte lane i
mem_rdata  out  32  raw 32-bit load word
mem_stall  out  1  freeze pipeline
sram_addr  out  ADDR_W  SRAM word address
sram_dq_o  out  32  write data to pads
sram_dq_oe  out  1  pad output enable
sram_dq_i  in  32  read data from pads
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte lane enables, active low

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE; ce_n/oe_n/we_n=1; be_n=4'hF; dq_oe=0; sram_addr=0; sram_dq_o=0; mem_rdata=0.
- Reset mid-cycle: WE_n rises and dq_oe drops immediately (asynchronous). The in-flight write is undefined in SRAM; no retry.
- All SRAM-side outputs are registered, with no combinational path to the pads. Each value is valid for the whole cycle the FSM is in the named state.
- mem_stall is combinational:
  - 1 when state is in {RD, WR_SETUP, WR_PULSE, WR_HOLD}.
  - 1 when state is IDLE and mem_req is high.
  - 0 otherwise, including DONE.
- States:
  - IDLE: when mem_req=1, latch addr, wdata and bwe. Next state is RD if mem_wr=0, else WR_SETUP.
  - RD: ce_n=0, oe_n=0, be_n=0000, dq_oe=0. A counter runs RD_CYCLES cycles. On the last cycle, mem_rdata <= sram_dq_i; next state is DONE.
  - WR_SETUP (1 cycle): ce_n=0, we_n=1, be_n=~bwe, dq_oe=1, dq_o=wdata.
  - WR_PULSE (WR_CYCLES cycles): as WR_SETUP, plus we_n=0.
  - WR_HOLD (1 cycle): we_n=1. Data and address are still driven; dq_oe stays 1.
  - DONE (1 cycle): ce_n=1, oe_n=1, dq_oe=0, stall=0. The pipeline advances on this edge. Next state is always IDLE.
- Latency, counted from the first request cycle to the first non-stall cycle:
  - Read: RD_CYCLES+1 stall cycles.
  - Write: WR_CYCLES+3 stall cycles.
- Back-to-back requests: each request incurs one IDLE cycle (stalled) before its SRAM cycle. Write-to-read gives at least one cycle of bus turnaround, because dq_oe drops in DONE.
- mem_rdata holds its value until the next read completes. Writes do not change it.
- mem_req deasserting mid-transaction does not abort the cycle; it completes.
- mem_bwe=0000 on a write still runs the full cycle with be_n=1111; no bytes change.
- Address bits above ADDR_W+1 are ignored (aliasing). Bits [1:0] are ignored.
- Wait counter width is clog2(max(RD_CYCLES, WR_CYCLES))+1. It reloads on every state entry.

Decomposition:
- Shared defines file: state encodings (SRAM_ST_IDLE…SRAM_ST_DONE, 3 bits) and the SRAM data width constant.
- No sub-module. The FSM and wait counter live in one module.
- The DQ tristate (dq_o/dq_oe/dq_i to inout) sits in the board top.

Test Plan:
- Read, RD_CYCLES=2: SRAM model returns 32'hDEADBEEF at word 0x00100, mem_addr=0x00000400 -> stall 3 cycles, oe_n low 2 cycles, mem_rdata=DEADBEEF in DONE.
- Write with mem_bwe=4'b0011, wdata=32'h1234ABCD, addr 0x8: WE_n low exactly 2 cycles, be_n=1100, sram_addr=2, then read back -> upper bytes unchanged, low half=ABCD.
- Write immediately followed by read at the same address: dq_oe=0 for at least 1 cycle before oe_n falls; the read returns the written word.
- rst_n asserted during WR_PULSE: we_n=1, dq_oe=0 within the same cycle (async), state IDLE, stall=mem_req after release.
- mem_req held low 20 cycles: all SRAM controls inactive, stall=0, mem_rdata stable.
- WR_CYCLES=3, RD_CYCLES=1 build: write stall = 6 cycles, read stall = 2 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the pipeline-side asynchronous SRAM controller:
// FSM state encodings and the external data-bus width.
package sram_ctrl_pkg;

    localparam int SRAM_DW = 32;

    typedef enum logic [2:0] {
        SRAM_ST_IDLE     = 3'd0,
        SRAM_ST_RD       = 3'd1,
        SRAM_ST_WR_SETUP = 3'd2,
        SRAM_ST_WR_PULSE = 3'd3,
        SRAM_ST_WR_HOLD  = 3'd4,
        SRAM_ST_DONE     = 3'd5
    } sram_state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Runs one multi-cycle asynchronous SRAM read or write per MEM-stage request,
// stalling the pipeline until the cycle completes. All pad-side outputs are registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_bwe,
    output logic [31:0]           mem_rdata,
    output logic                  mem_stall,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [SRAM_DW-1:0]    sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [SRAM_DW-1:0]    sram_dq_i,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    sram_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          bwe_q, bwe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SRAM_DW-1:0]  dq_o_q, dq_o_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [3:0]          be_n_q, be_n_d;
    logic                accept;
    logic                cnt_last;
    logic                unused_addr_bits;

    assign accept           = (state_q == SRAM_ST_IDLE) && mem_req;
    assign cnt_last         = (cnt_q == '0);
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign mem_stall = accept
                     || (state_q == SRAM_ST_RD)
                     || (state_q == SRAM_ST_WR_SETUP)
                     || (state_q == SRAM_ST_WR_PULSE)
                     || (state_q == SRAM_ST_WR_HOLD);

    // Next state, request latches and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bwe_d   = bwe_q;
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;
        rdata_d = rdata_q;
        case (state_q)
            SRAM_ST_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr[ADDR_W+1:2];
                    dq_o_d  = mem_wdata;
                    bwe_d   = mem_bwe;
                    state_d = mem_wr ? SRAM_ST_WR_SETUP : SRAM_ST_RD;
                end
            end
            SRAM_ST_RD: begin
                if (cnt_last) begin
                    rdata_d = sram_dq_i;
                    state_d = SRAM_ST_DONE;
                end
            end
            SRAM_ST_WR_SETUP: state_d = SRAM_ST_WR_PULSE;
            SRAM_ST_WR_PULSE: if (cnt_last) state_d = SRAM_ST_WR_HOLD;
            SRAM_ST_WR_HOLD:  state_d = SRAM_ST_DONE;
            SRAM_ST_DONE:     state_d = SRAM_ST_IDLE;
            default:          state_d = SRAM_ST_IDLE;
        endcase

        if (state_d != state_q) begin
            if (state_d == SRAM_ST_RD) begin
                cnt_d = RD_LOAD;
            end else if (state_d == SRAM_ST_WR_PULSE) begin
                cnt_d = WR_LOAD;
            end else begin
                cnt_d = '0;
            end
        end else if (!cnt_last) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pad controls are decoded from the state being entered so they are
    // registered and change on the same edge as the state.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = 4'hF;
        dq_oe_d = 1'b0;
        case (state_d)
            SRAM_ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            SRAM_ST_WR_SETUP, SRAM_ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~bwe_d;
                dq_oe_d = 1'b1;
            end
            SRAM_ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~bwe_d;
                dq_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SRAM_ST_IDLE;
            cnt_q   <= '0;
            bwe_q   <= '0;
            addr_q  <= '0;
            dq_o_q  <= '0;
            rdata_q <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bwe_q   <= bwe_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
            rdata_q <= rdata_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
        end
    end

    assign mem_rdata  = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM device, word-level reference memory,
// randomized read/write traffic plus directed corner cases and a second build.
module tb_sram_ctrl;

  localparam int ADDR_W = 18;
  localparam int RD_CYC = 2;
  localparam int WR_CYC = 2;

  logic clk;
  logic rst_n;

  // instance A (RD=2, WR=2)
  logic              mem_req, mem_wr;
  logic [31:0]       mem_addr, mem_wdata;
  logic [3:0]        mem_bwe;
  logic [31:0]       mem_rdata;
  logic              mem_stall;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o, sram_dq_i;
  logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]        sram_be_n;

  // instance B (RD=1, WR=3)
  logic              b_req, b_wr;
  logic [31:0]       b_addr, b_wdata;
  logic [3:0]        b_bwe;
  logic [31:0]       b_rdata;
  logic              b_stall;
  logic [ADDR_W-1:0] b_sram_addr;
  logic [31:0]       b_dq_o, b_dq_i;
  logic              b_dq_oe, b_ce_n, b_oe_n, b_we_n;
  logic [3:0]        b_be_n;

  sram_ctrl #(.ADDR_W(ADDR_W), .RD_CYCLES(RD_CYC), .WR_CYCLES(WR_CYC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bwe(mem_bwe),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  sram_ctrl #(.ADDR_W(ADDR_W), .RD_CYCLES(1), .WR_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .mem_req(b_req), .mem_wr(b_wr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_bwe(b_bwe),
    .mem_rdata(b_rdata), .mem_stall(b_stall),
    .sram_addr(b_sram_addr), .sram_dq_o(b_dq_o), .sram_dq_oe(b_dq_oe),
    .sram_dq_i(b_dq_i), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_be_n(b_be_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- SRAM device model ----------------
  logic [31:0]       sram_mem [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      sram_mem[pl_addr] <= pl_data;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) sram_mem[sram_addr][8*i +: 8] <= sram_dq_o[8*i +: 8];
    end
  end

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 32'h0BAD_F00D;
  assign b_dq_i    = (!b_ce_n && !b_oe_n) ? 32'hA5C3_3C5A : 32'h0;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [logic [ADDR_W-1:0]];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] w);
    return exp_mem.exists(w) ? exp_mem[w] : 32'h0;
  endfunction

  // Bus-level rules watched on every cycle.
  logic last_dq_oe = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_oe_n) check("turnaround", {31'b0, last_dq_oe}, 32'h0);
      if (!sram_we_n) check("we_needs_dq_oe", {31'b0, sram_dq_oe}, 32'h1);
    end
    last_dq_oe <= sram_dq_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [ADDR_W-1:0] w, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = w; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    exp_mem[w] = d;
  endtask

  function automatic logic [31:0] mk_addr(input logic [ADDR_W-1:0] w);
    logic [31:0] a;
    a = $urandom();
    a[ADDR_W+1:2] = w;
    return a;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] bwe, input logic drop);
    logic [ADDR_W-1:0] w;
    logic [31:0]       m;
    int stalls, we_lo, oe_lo;
    w = addr[ADDR_W+1:2];
    if (wr) begin
      m = model_read(w);
      for (int i = 0; i < 4; i++) if (bwe[i]) m[8*i +: 8] = wdata[8*i +: 8];
      exp_mem[w] = m;
    end else begin
      exp_q.push_back(model_read(w));
    end
    mem_req = 1'b1; mem_wr = wr; mem_addr = addr; mem_wdata = wdata; mem_bwe = bwe;
    stalls = 0; we_lo = 0; oe_lo = 0;
    @(negedge clk);
    while (mem_stall && stalls < 50) begin
      stalls++;
      if (!sram_ce_n) check("sram_addr", 32'(sram_addr), 32'(w));
      if (!sram_we_n) begin
        we_lo++;
        check("wr_be_n", {28'b0, sram_be_n}, {28'b0, ~bwe});
        check("wr_dq_o", sram_dq_o, wdata);
      end
      if (!sram_oe_n) begin
        oe_lo++;
        check("rd_be_n", {28'b0, sram_be_n}, 32'h0);
      end
      if (drop && stalls == 2) mem_req = 1'b0;
      @(negedge clk);
    end
    check("stall_cycles", stalls, wr ? (WR_CYC + 3) : (RD_CYC + 1));
    check("we_low_cycles", we_lo, wr ? WR_CYC : 0);
    check("oe_low_cycles", oe_lo, wr ? 0 : RD_CYC);
    check("done_ctrl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
    if (!wr) last_rd = exp_q.pop_front();
    check("rdata", mem_rdata, last_rd);
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic op_b(input logic wr, output int stalls, output int lo);
    b_req = 1'b1; b_wr = wr; b_addr = $urandom(); b_wdata = $urandom(); b_bwe = 4'hF;
    stalls = 0; lo = 0;
    @(negedge clk);
    while (b_stall && stalls < 50) begin
      stalls++;
      if (wr ? !b_we_n : !b_oe_n) lo++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] pool [8];

  initial begin
    int n, s, lo;
    logic [31:0] rd_hold;
    rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_bwe = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_bwe = '0;
    last_rd = 32'h0;

    @(negedge clk);
    check("rst_ctrl", {24'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, 32'hEF);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_o", sram_dq_o, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_stall", {31'b0, mem_stall}, 32'h0);

    preload(18'h00100, 32'hDEAD_BEEF);
    preload(18'h00002, 32'h5566_7788);
    for (int i = 0; i < 8; i++) begin
      pool[i] = ADDR_W'($urandom_range(0, 32'h3FEFF));
      preload(pool[i], $urandom());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed read of a preloaded word
    do_op(1'b0, 32'h0000_0400, 32'h0, 4'h0, 1'b0);
    check("deadbeef", mem_rdata, 32'hDEAD_BEEF);

    // partial write, then back-to-back read of the same word
    do_op(1'b1, 32'h0000_0008, 32'h1234_ABCD, 4'b0011, 1'b0);
    do_op(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0);
    check("partial_merge", mem_rdata, 32'h5566_ABCD);

    // empty byte mask still runs the full cycle and changes nothing
    do_op(1'b1, mk_addr(pool[0]), 32'hFFFF_FFFF, 4'b0000, 1'b0);
    do_op(1'b0, mk_addr(pool[0]), 32'h0, 4'h0, 1'b0);

    // idle: nothing moves for 20 cycles
    rd_hold = last_rd;
    repeat (20) begin
      @(negedge clk);
      check("idle_ctrl", {24'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_be_n}, 32'hEF);
      check("idle_stall", {31'b0, mem_stall}, 32'h0);
      check("idle_rdata", mem_rdata, rd_hold);
    end
    @(posedge clk); #1;

    // randomized traffic over an aliased address pool
    for (int k = 0; k < 150; k++) begin
      logic [ADDR_W-1:0] w;
      w = pool[$urandom_range(0, 7)];
      do_op(1'(($urandom_range(0, 1))), mk_addr(w), $urandom(),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // asynchronous reset in the middle of the write pulse
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = {12'h0, 18'h3FF00, 2'b00};
    mem_wdata = $urandom(); mem_bwe = 4'hF;
    n = 0;
    @(negedge clk);
    while (sram_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_pulse", {31'b0, sram_we_n}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_we_n", {31'b0, sram_we_n}, 32'h1);
    check("async_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
    check("async_ce_n", {31'b0, sram_ce_n}, 32'h1);
    check("async_stall", {31'b0, mem_stall}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_stall_req1", {31'b0, mem_stall}, 32'h1);
    mem_req = 1'b0;
    #1;
    check("post_rst_stall_req0", {31'b0, mem_stall}, 32'h0);
    check("post_rst_rdata", mem_rdata, 32'h0);
    last_rd = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) do_op(1'b0, mk_addr(pool[i]), 32'h0, 4'h0, 1'b0);

    // second build: RD_CYCLES=1, WR_CYCLES=3
    check("b_rdata_init", b_rdata, 32'h0);
    op_b(1'b1, s, lo);
    check("b_wr_stall", s, 6);
    check("b_we_low", lo, 3);
    op_b(1'b0, s, lo);
    check("b_rd_stall", s, 2);
    check("b_oe_low", lo, 1);
    check("b_rdata", b_rdata, 32'hA5C3_3C5A);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
